// File: rtl/conv_enc_pack.sv
// conv_enc_pack
// Rate 1/2 or 1/3, K=3 convolutional encoder with a zero tail. Coded symbols
// are packed MSB-first into 16-bit frames.
//
// Code rate select (i_code_rate): 0 = rate 1/2, 1 = rate 1/3.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active low
//   i_code_rate   rate select, latched on the first accepted bit of a packet
//   i_bit         information bit
//   i_valid       i_bit / i_last valid
//   i_last        final information bit of the packet
//   o_ready       a bit can be accepted this cycle (decoded from state)
//   o_data_frame  packed coded frame
//   o_nsym        number of valid symbols in o_data_frame
//   o_valid       frame valid
//   i_ready       downstream accepts the frame
//   o_last        frame holds the final tail symbol of the packet
//
// FSM states
//   state | meaning
//   IDLE  | waiting for the first bit of a packet, ready high
//   ENC   | mid-packet, one symbol per accepted bit
//   FLUSH | encoding the two zero tail bits, ready low
//   OUT   | frame presented, held until i_ready
module conv_enc_pack #(
  parameter int FRAME_W = 16,
  parameter int K       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_code_rate,
  input  logic               i_bit,
  input  logic               i_valid,
  input  logic               i_last,
  output logic               o_ready,
  output logic [FRAME_W-1:0] o_data_frame,
  output logic [3:0]         o_nsym,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last
);

  typedef enum logic [1:0] {IDLE, ENC, FLUSH, OUT} state_t;

  state_t       state;
  logic         rate3_q;
  logic [K-2:0] sr;         // sr[0] = s1 (previous bit), sr[1] = s2
  logic [1:0]   tail_left;  // tail symbols still to encode

  logic               accept;
  logic               rate3;
  logic               enc_u;
  logic               g0;
  logic               g1;
  logic [FRAME_W-1:0] sym_field;
  logic [FRAME_W-1:0] sym_placed;
  logic [4:0]         shamt;
  logic [3:0]         nsym_next;
  logic [3:0]         cap;
  logic               frame_full;

  assign o_ready = (state == IDLE) || (state == ENC);
  assign accept  = i_valid && o_ready;

  // The first bit of a packet is encoded in the same cycle the rate is latched.
  assign rate3 = (state == IDLE) ? i_code_rate : rate3_q;
  assign enc_u = (state == FLUSH) ? 1'b0 : i_bit;

  assign g0 = enc_u ^ sr[0] ^ sr[1];
  assign g1 = enc_u ^ sr[1];

  always_comb begin
    sym_field = '0;
    if (rate3) sym_field[FRAME_W-1 -: 3] = {g0, g0, g1};
    else       sym_field[FRAME_W-1 -: 2] = {g0, g1};
  end

  // o_nsym doubles as the append position: symbol n starts n*R bits below the MSB.
  assign shamt      = rate3 ? ({1'b0, o_nsym} + {o_nsym, 1'b0}) : {o_nsym, 1'b0};
  assign sym_placed = sym_field >> shamt;
  assign nsym_next  = o_nsym + 4'd1;
  assign cap        = rate3 ? 4'd5 : 4'd8;
  assign frame_full = (nsym_next == cap);

  // o_data_frame / o_nsym accumulate in place; o_valid qualifies them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rate3_q      <= 1'b0;
      sr           <= '0;
      tail_left    <= 2'd0;
      o_data_frame <= '0;
      o_nsym       <= 4'd0;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rate3_q      <= i_code_rate;
            o_data_frame <= o_data_frame | sym_placed;
            o_nsym       <= nsym_next;
            sr           <= {sr[K-3:0], enc_u};
            if (i_last) begin
              state     <= FLUSH;
              tail_left <= 2'd2;
            end else begin
              state <= ENC;
            end
          end
        end

        ENC: begin
          if (accept) begin
            o_data_frame <= o_data_frame | sym_placed;
            o_nsym       <= nsym_next;
            sr           <= {sr[K-3:0], enc_u};
            if (frame_full) begin
              // A last bit that fills the frame defers its flush until after the handshake.
              state     <= OUT;
              o_valid   <= 1'b1;
              o_last    <= 1'b0;
              tail_left <= i_last ? 2'd2 : 2'd0;
            end else if (i_last) begin
              state     <= FLUSH;
              tail_left <= 2'd2;
            end
          end
        end

        FLUSH: begin
          o_data_frame <= o_data_frame | sym_placed;
          o_nsym       <= nsym_next;
          sr           <= {sr[K-3:0], enc_u};
          tail_left    <= tail_left - 2'd1;
          if (tail_left == 2'd1) begin
            state   <= OUT;
            o_valid <= 1'b1;
            o_last  <= 1'b1;
          end else if (frame_full) begin
            state   <= OUT;
            o_valid <= 1'b1;
            o_last  <= 1'b0;
          end
        end

        OUT: begin
          if (i_ready) begin
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_data_frame <= '0;
            o_nsym       <= 4'd0;
            if (tail_left != 2'd0) state <= FLUSH;
            else if (o_last)       state <= IDLE;
            else                   state <= ENC;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_pack.sv
module tb_conv_enc_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_code_rate;
  logic        i_bit;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [15:0] o_data_frame;
  logic [3:0]  o_nsym;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_last;

  conv_enc_pack dut (
    .clk          (clk),
    .rst          (rst),
    .i_code_rate  (i_code_rate),
    .i_bit        (i_bit),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_data_frame (o_data_frame),
    .o_nsym       (o_nsym),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  n;
    logic        l;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int stall_req = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: convolve the packet plus two zero tail bits, then cut the
  // symbol stream into frames of at most 8 (rate 1/2) or 5 (rate 1/3) symbols.
  task automatic model_packet(input logic [31:0] bv, input int n, input logic r3);
    int s1, s2, u, g0, g1, sym, k, w, cap, d;
    frame_t f;
    s1 = 0; s2 = 0; k = 0; d = 0;
    w   = r3 ? 3 : 2;
    cap = r3 ? 5 : 8;
    for (int j = 0; j < n + 2; j++) begin
      u   = (j < n) ? int'(bv[j]) : 0;
      g0  = u ^ s1 ^ s2;
      g1  = u ^ s2;
      sym = r3 ? (g0 * 4 + g0 * 2 + g1) : (g0 * 2 + g1);
      d   = d + sym * (1 << (16 - (k + 1) * w));
      k++;
      s2 = s1;
      s1 = u;
      if (k == cap || j == n + 1) begin
        f.d = 16'(d);
        f.n = 4'(k);
        f.l = (j == n + 1);
        exp_q.push_back(f);
        k = 0;
        d = 0;
      end
    end
  endtask

  // Hand-computed frames that pin the reference model.
  task automatic pin(input int idx, input logic [15:0] d, input logic [3:0] n, input logic l);
    if (idx >= exp_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL model_pin_missing: frame %0d absent, queue holds %0d", idx, exp_q.size());
    end else begin
      check("model_pin_data", exp_q[idx].d, d);
      check("model_pin_nsym", exp_q[idx].n, n);
      check("model_pin_last", exp_q[idx].l, l);
    end
  endtask

  // Presents real data only when o_ready is seen high; while it is low the
  // inputs carry random junk, which the DUT must ignore. Rate is randomised
  // after the first bit to show mid-packet changes have no effect.
  task automatic send_packet(input logic [31:0] bv, input int n, input logic rate);
    for (int i = 0; i < n; i++) begin
      int  guard;
      bit  done;
      guard = 0;
      done  = 0;
      while (!done) begin
        @(negedge clk);
        if (o_ready) begin
          i_valid     = 1'b1;
          i_bit       = bv[i];
          i_last      = (i == n - 1);
          i_code_rate = (i == 0) ? rate : 1'($urandom_range(0, 1));
          done        = 1;
        end else begin
          i_valid     = 1'($urandom_range(0, 1));
          i_bit       = 1'($urandom_range(0, 1));
          i_last      = 1'($urandom_range(0, 1));
          i_code_rate = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        guard++;
        if (!done && guard > 300) begin
          n_checks++;
          n_fail++;
          $display("FAIL input_accept_timeout: bit %0d not accepted, o_ready=%0b", i, o_ready);
          done = 1;
        end
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    check(name, exp_q.size(), 0);
    @(negedge clk);
    check("ready_after_packet", o_ready, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (stall_cnt < stall_req) begin
      i_ready = 1'b0;
      if (o_valid) stall_cnt++;
    end else begin
      i_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got 0x%0h nsym %0d, no frame expected", o_data_frame, o_nsym);
      end else begin
        check("frame_data", o_data_frame, exp_q[0].d);
        check("frame_nsym", o_nsym, exp_q[0].n);
        check("frame_last", o_last, exp_q[0].l);
        check("ready_low_while_valid", o_ready, 0);
        if (i_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    i_valid     = 1'b0;
    i_bit       = 1'b0;
    i_last      = 1'b0;
    i_code_rate = 1'b0;
    rst         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", o_data_frame, 0);
    check("reset_nsym", o_nsym, 0);
    check("reset_valid", o_valid, 0);
    check("reset_last", o_last, 0);
    check("reset_ready", o_ready, 1);
    rst = 1'b1;

    // rate 1/2, bits 1,0,1,1
    model_packet(32'b1101, 4, 1'b0);
    pin(0, 16'hE170, 4'd6, 1'b1);
    send_packet(32'b1101, 4, 1'b0);
    wait_drain("drain_r2_1011");

    // rate 1/3, single bit 1
    model_packet(32'b1, 1, 1'b1);
    pin(0, 16'hFB80, 4'd3, 1'b1);
    send_packet(32'b1, 1, 1'b1);
    wait_drain("drain_r3_single");

    // rate 1/2, eight 1s fill a frame held under backpressure, then 0 with last
    model_packet(32'h0FF, 9, 1'b0);
    pin(0, 16'hDAAA, 4'd8, 1'b0);
    pin(1, 16'h7000, 4'd3, 1'b1);
    stall_req = 5;
    send_packet(32'h0FF, 9, 1'b0);
    wait_drain("drain_r2_backpressure");
    check("stall_cycles_seen", stall_cnt, 5);

    // rate 1/2, 7 bits: first tail symbol fills frame 1, second goes alone
    model_packet(32'h4D, 7, 1'b0);
    pin(0, exp_q[0].d, 4'd8, 1'b0);
    pin(1, exp_q[1].d, 4'd1, 1'b1);
    send_packet(32'h4D, 7, 1'b0);
    wait_drain("drain_r2_seven");

    // rate 1/2, 6 bits: second tail symbol exactly fills the frame
    model_packet(32'h0B, 6, 1'b0);
    check("model_exact_fill_frames", exp_q.size(), 1);
    send_packet(32'h0B, 6, 1'b0);
    wait_drain("drain_r2_exact");

    // rate 1/3, 3 bits: exact fill at capacity 5
    model_packet(32'b101, 3, 1'b1);
    check("model_r3_exact_frames", exp_q.size(), 1);
    send_packet(32'b101, 3, 1'b1);
    wait_drain("drain_r3_exact");

    // rate 1/3, 6 bits spanning two frames
    model_packet(32'h2D, 6, 1'b1);
    send_packet(32'h2D, 6, 1'b1);
    wait_drain("drain_r3_two_frames");

    // reset while flushing discards everything
    send_packet(32'b11, 2, 1'b0);
    check("busy_in_flush", o_ready, 0);
    rst = 1'b0;
    #1;
    check("midreset_data", o_data_frame, 0);
    check("midreset_nsym", o_nsym, 0);
    check("midreset_valid", o_valid, 0);
    check("midreset_last", o_last, 0);
    check("midreset_ready", o_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    model_packet(32'b1, 1, 1'b0);
    pin(0, 16'hEC00, 4'd3, 1'b1);
    send_packet(32'b1, 1, 1'b0);
    wait_drain("drain_after_reset");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
